// File: rtl/gpi_filter.sv
// Input conditioner for gpio: two-flop synchroniser, prescaled debounce and edge-capture interrupt.
// Define GPI_FILTER_EDGE_IRQ_EN to build rise_en/fall_en/pend and irq; otherwise irq is tied to 0.
module gpi_filter #(
    parameter int unsigned WIDTH  = 8,
    parameter int unsigned STABLE = 3
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             we,
    input  logic [3:0]       sel,
    input  logic [31:0]      dat,
    output logic [31:0]      rdt,
    input  logic [WIDTH-1:0] pin,
    output logic [WIDTH-1:0] clean,
    output logic             irq
);

    logic                  we1_q;
    logic [WIDTH-1:0]      s0_q, s1_q;
    logic [WIDTH-1:0]      clean_q, clean_d;
    logic [WIDTH-1:0][3:0] cnt_q, cnt_d;
    logic [7:0]            pcnt_q, pcnt_d;
    logic [7:0]            div_q, div_d;
    logic                  tick;
    logic                  div_wr;

    assign div_wr = we1_q && sel[3];
    assign tick   = (pcnt_q == div_q);

    always_comb begin
        div_d  = div_q;
        pcnt_d = pcnt_q + 8'd1;
        if (div_wr) begin
            div_d  = dat[31:24];
            pcnt_d = '0;
        end else if (tick) begin
            pcnt_d = '0;
        end
    end

    // A single agreeing tick restarts the count, so short glitches never reach clean.
    always_comb begin
        cnt_d   = cnt_q;
        clean_d = clean_q;
        if (tick) begin
            for (int i = 0; i < WIDTH; i++) begin
                if (s1_q[i] == clean_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == 4'(STABLE - 1)) begin
                    clean_d[i] = s1_q[i];
                    cnt_d[i]   = '0;
                end else begin
                    cnt_d[i] = cnt_q[i] + 4'd1;
                end
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we1_q   <= 1'b0;
            s0_q    <= '0;
            s1_q    <= '0;
            clean_q <= '0;
            cnt_q   <= '0;
            pcnt_q  <= '0;
            div_q   <= 8'hFF;
        end else begin
            we1_q   <= !we1_q && we;
            s0_q    <= pin;
            s1_q    <= s0_q;
            clean_q <= clean_d;
            cnt_q   <= cnt_d;
            pcnt_q  <= pcnt_d;
            div_q   <= div_d;
        end
    end

    assign clean = clean_q;

`ifdef GPI_FILTER_EDGE_IRQ_EN
    logic [WIDTH-1:0] rise_en_q, fall_en_q, pend_q, pend_d, pend_set, pend_clr;

    assign pend_set = (rise_en_q & clean_d & ~clean_q) | (fall_en_q & ~clean_d & clean_q);
    assign pend_clr = (we1_q && sel[2]) ? WIDTH'(dat[23:16]) : '0;
    // Set wins over a same-cycle write-1-to-clear.
    assign pend_d   = (pend_q & ~pend_clr) | pend_set;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rise_en_q <= '0;
            fall_en_q <= '0;
            pend_q    <= '0;
        end else begin
            if (we1_q && sel[0]) rise_en_q <= WIDTH'(dat[7:0]);
            if (we1_q && sel[1]) fall_en_q <= WIDTH'(dat[15:8]);
            pend_q <= pend_d;
        end
    end

    assign irq = |pend_q;
    assign rdt = {8'(fall_en_q), 8'(rise_en_q), 8'(pend_q), 8'(clean_q)};
`else
    logic unused_bus;
    assign unused_bus = ^{sel[2:0], dat[23:0]};

    assign irq = 1'b0;
    assign rdt = {24'h0, 8'(clean_q)};
`endif

endmodule

// File: tb/tb_gpi_filter.sv
// Directed bench for gpi_filter: reset, tick period, latency, glitch rejection, edge interrupts.
// Edge-interrupt checks are built only when GPI_FILTER_EDGE_IRQ_EN is defined.
module tb_gpi_filter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        we  = 1'b0;
    logic [3:0]  sel = '0;
    logic [31:0] dat = '0;
    logic [31:0] rdt;
    logic [7:0]  pin = '0;
    logic [7:0]  clean;
    logic        irq;

    int errors = 0;
    int checks = 0;

    gpi_filter #(.WIDTH(8), .STABLE(3)) dut (
        .clk   (clk),
        .rst   (rst),
        .we    (we),
        .sel   (sel),
        .dat   (dat),
        .rdt   (rdt),
        .pin   (pin),
        .clean (clean),
        .irq   (irq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Bus write: we held for two cycles, registers update on the second edge.
    task automatic bus_write(input logic [3:0] s, input logic [31:0] d);
        we  = 1'b1;
        sel = s;
        dat = d;
        step(2);
        we  = 1'b0;
        sel = '0;
        dat = '0;
    endtask

    initial begin
        step(2);
        check("reset_clean", {24'h0, clean}, 32'h0);
        check("reset_irq", {31'h0, irq}, 32'h0);
        check("reset_rdt", rdt, 32'h0);

        // Tick period 256 with div=FF: clean changes on the third tick, edge 768.
        pin = 8'hFF;
        @(posedge clk);
        #1 rst = 1'b0;
        step(767);
        check("div_ff_before", {24'h0, clean}, 32'h0);
        step(1);
        check("div_ff_after", {24'h0, clean}, 32'h0000_00FF);

        // Asynchronous reset mid-cycle.
        #2 rst = 1'b1;
        #1;
        check("midrst_clean", {24'h0, clean}, 32'h0);
        check("midrst_irq", {31'h0, irq}, 32'h0);
        check("midrst_rdt", rdt, 32'h0);
        pin = 8'h00;
        step(1);
        rst = 1'b0;

        bus_write(4'b1000, 32'h0000_0000);
`ifdef GPI_FILTER_EDGE_IRQ_EN
        bus_write(4'b0011, 32'h0000_0201);
        check("enables_rd", rdt, 32'h0201_0000);
`endif

        // Latency: div=0, pin[0] rises before edge 1, clean at edge 5.
        pin = 8'h01;
        step(4);
        check("lat_edge4", {24'h0, clean}, 32'h0);
        step(1);
        check("lat_edge5", {24'h0, clean}, 32'h01);
        check("lat_rdt_lo", {24'h0, rdt[7:0]}, 32'h01);
`ifdef GPI_FILTER_EDGE_IRQ_EN
        check("lat_pend", {24'h0, rdt[15:8]}, 32'h01);
        check("lat_irq", {31'h0, irq}, 32'h1);
`endif

        pin = 8'h03;
        step(6);
        check("both_up", {24'h0, clean}, 32'h03);
`ifdef GPI_FILTER_EDGE_IRQ_EN
        check("pend_rises", {24'h0, rdt[15:8]}, 32'h01);
`endif
        pin = 8'h00;
        step(6);
        check("both_down", {24'h0, clean}, 32'h00);
`ifdef GPI_FILTER_EDGE_IRQ_EN
        check("pend_falls", {24'h0, rdt[15:8]}, 32'h03);
        check("irq_falls", {31'h0, irq}, 32'h1);
        bus_write(4'b0100, 32'h0003_0000);
        check("w1c_pend", {24'h0, rdt[15:8]}, 32'h00);
        check("w1c_irq", {31'h0, irq}, 32'h0);
        pin = 8'h01;
        step(6);
        check("repend", {24'h0, rdt[15:8]}, 32'h01);
`else
        check("no_irq_rdt_hi", {8'h0, rdt[31:8]}, 32'h0);
        check("no_irq", {31'h0, irq}, 32'h0);
`endif

        // Two-cycle write produces exactly one we1 pulse.
        we  = 1'b1;
        sel = 4'b0100;
        dat = 32'h00FF_0000;
        step(1);
        check("we1_first", {31'h0, dut.we1_q}, 32'h1);
        step(1);
        check("we1_second", {31'h0, dut.we1_q}, 32'h0);
        we  = 1'b0;
        sel = '0;
        dat = '0;
        step(1);
        check("we1_after", {31'h0, dut.we1_q}, 32'h0);
`ifdef GPI_FILTER_EDGE_IRQ_EN
        check("twocyc_pend", {24'h0, rdt[15:8]}, 32'h00);

        // Collision: W1C in the same cycle clean[0] rises with rise_en[0].
        pin = 8'h00;
        step(6);
        pin = 8'h01;
        step(3);
        we  = 1'b1;
        sel = 4'b0100;
        dat = 32'h0001_0000;
        step(1);
        step(1);
        we  = 1'b0;
        sel = '0;
        dat = '0;
        check("coll_clean", {24'h0, clean}, 32'h01);
        check("coll_pend", {24'h0, rdt[15:8]}, 32'h01);
        step(1);
        check("coll_pend_hold", {24'h0, rdt[15:8]}, 32'h01);
        pin = 8'h00;
        step(6);
`endif

        // Glitch rejection with div=0: two-cycle pulse.
        pin = 8'h08;
        step(2);
        pin = 8'h00;
        step(10);
        check("glitch2_div0", {31'h0, clean[3]}, 32'h0);

        bus_write(4'b1000, 32'h0300_0000);
        pin = 8'h08;
        step(8);
        pin = 8'h00;
        step(20);
        check("glitch8_div3", {31'h0, clean[3]}, 32'h0);

        pin = 8'h08;
        step(16);
        pin = 8'h00;
        step(3);
        check("pulse16_div3", {31'h0, clean[3]}, 32'h1);
        step(30);
        check("pulse16_settle", {31'h0, clean[3]}, 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout: observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/gpi_filter.md
# gpi_filter

Input conditioning stage that sits directly upstream of `gpio` and feeds its `gpi` port. Each raw input pin is synchronised, then debounced with a programmable sample tick and a stability count. The clean levels are presented to `gpio`. Rising and falling edges of the clean levels are latched into pending bits that drive a single level interrupt. The block has its own control registers on the same byte-select write bus that `gpio` uses.

## Interface
- `WIDTH`, 8: number of input pins; all byte lanes below assume 8.
- `STABLE`, 3: consecutive differing ticks required before a clean level changes; legal range 1..15.
- `clk`  in  1: system clock.
- `rst`  in  1: asynchronous, active-high reset.
- `we`  in  1: write enable; the bus holds it for 2 cycles per write.
- `sel`  in  4: byte-lane selects.
- `dat`  in  32: write data.
- `rdt`  out  32: read data: [7:0] clean, [15:8] pend, [23:16] rise_en, [31:24] fall_en.
- `pin`  in  WIDTH: raw asynchronous inputs.
- `clean`  out  WIDTH: debounced levels; connects to `gpio.gpi`.
- `irq`  out  1: `|pend`; combinational from registers.

## Operation
- **Write strobe**
  - `we1 <= !we1 && we`.
  - Register writes happen only when `we1` is high: one update per bus write, on the cycle after `we` rises.
- **Lane priority.** Lanes are not exclusive; all selected lanes act in the same `we1` cycle.
  - `sel[0]`: `rise_en <= dat[7:0]`.
  - `sel[1]`: `fall_en <= dat[15:8]`.
  - `sel[2]`: write-1-to-clear `pend` with `dat[23:16]`.
  - `sel[3]`: `div <= dat[31:24]`. `div` is not readable.
- **Synchroniser.** Two flops: `s0 <= pin`, `s1 <= s0`.
- **Prescaler**
  - 8-bit counter `pcnt`.
  - When `pcnt == div`: `tick` = 1 and `pcnt <= 0`; otherwise `pcnt` increments.
  - `div = 0` gives a tick every cycle. Tick period is `div+1` cycles.
  - A write to `div` also clears `pcnt`.
- **Debounce.** Each bit has a 4-bit counter `cnt[i]`, updated only on `tick`:
  - `s1[i] == clean[i]`: `cnt[i] <= 0`.
  - Differ and `cnt[i] == STABLE-1`: `clean[i] <= s1[i]`, `cnt[i] <= 0`.
  - Differ otherwise: `cnt[i] <= cnt[i]+1`.
  - Any single agreeing tick restarts the count. Glitches shorter than `STABLE` ticks never reach `clean`.
- **Edge capture**
  - On the same edge that `clean[i]` goes 0→1, `pend[i] <= 1` if `rise_en[i]`.
  - On the same edge that it goes 1→0, `pend[i] <= 1` if `fall_en[i]`.
  - If a set and a W1C of the same bit occur in the same cycle, the set wins.
  - Changing an enable never sets or clears `pend`.

## Timing
- **Reset values**
  - `s0`, `s1`, `clean`, `cnt`, `pend`, `rise_en`, `fall_en`, `pcnt`, `we1` = 0.
  - `div` = 8'hFF.
  - Outputs: `clean` = 0, `irq` = 0, `rdt` = 0.
- **Latency.** Take `div = 0`, `STABLE = 3`, and `pin` changing before edge 1. The sequence is `s0` at edge 1, `s1` at edge 2, counting at edges 3 and 4, and `clean` plus `pend` update at edge 5. `irq` rises in the same cycle as `pend`.
- **General latency.** 2 cycles plus `STABLE` ticks, plus up to `div` cycles of tick phase.
- **Read path.** `rdt` is combinational from registers with no read latency.
- **Register writes.** New values are visible the cycle after `we1`.
- **Reset mid-operation.** The asynchronous reset returns all state to reset values immediately. `clean` drops to 0 without setting `pend`.
- **Counter limit.** `cnt` never exceeds `STABLE-1`.

## Configuration
- Macro `GPI_FILTER_EDGE_IRQ_EN`.
- **Defined:** edge capture, `rise_en`, `fall_en`, `pend` and `irq` are present as described.
- **Undefined**
  - Those registers are absent.
  - `sel[0..2]` writes are ignored.
  - `rdt[31:8]` reads as 0.
  - `irq` is tied to 0.
  - Synchroniser, prescaler, debounce and `div` behave identically in both builds.

## Test plan
- **Reset:** assert `rst` mid-run with `pin` = 8'hFF → `clean` = 0, `irq` = 0, `rdt` = 0 immediately. After release, the first tick arrives 256 cycles later (`div` = FF).
- **Latency:** write `div` = 0, then `pin[0]` 0→1 → `clean[0]` rises exactly 5 cycles later and `rdt[7:0]` = 8'h01.
- **Glitch rejection:** `div` = 0, `pin[3]` high for 2 cycles then low → `clean[3]` stays 0.
  - Same with `div` = 3 and a pulse of 8 cycles → `clean[3]` stays 0.
  - A pulse of 16 cycles → `clean[3]` rises.
- **Edge interrupt:** `rise_en` = 8'h01, `fall_en` = 8'h02. Toggle `pin[0]` and `pin[1]` up then down → `pend` = 8'h01 after the rises and 8'h03 after the falls. `irq` = 1.
  - W1C `dat[23:16]` = 8'h03 → `pend` = 0, `irq` = 0.
- **Collision:** issue a W1C of `pend[0]` on the exact cycle that `clean[0]` rises with `rise_en[0]` set → `pend[0]` = 1 afterwards.
- **Two-cycle write:** `we` held 2 cycles with `sel` = 4'b0100 and `dat[23:16]` = FF → `pend` cleared once. No extra `we1` pulse occurs, so `we1` is high for exactly 1 cycle.
